// File: rtl/pipeline_exe_pkg.sv
// rtl/pipeline_exe_pkg.sv - shared execute-stage definitions
// Purpose: ALU operation codes, data-memory type and write-back source codes
//          used by pipeline_exe and exe_alu.
// Ports:   none (package).
package pipeline_exe_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RESULT_SRC_ALU = 2'd0,
    RESULT_SRC_MEM = 2'd1,
    RESULT_SRC_IMM = 2'd2,
    RESULT_SRC_PC4 = 2'd3
  } result_src_e;

  localparam logic [2:0] DMEM_NONE = 3'd0;

endpackage

// File: rtl/exe_alu.sv
// rtl/exe_alu.sv - combinational 32-bit ALU of the execute stage
// Purpose: result = f(op, a, b); codes 11..31 give 0. Shifts use b[4:0].
// Ports:   op (5) in, a (XLEN) in, b (XLEN) in, result (XLEN) out.
module exe_alu
  import pipeline_exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  always_comb begin
    shamt       = b[4:0];
    lt_signed   = $signed(a) < $signed(b);
    lt_unsigned = a < b;
    result      = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_exe.sv
// rtl/pipeline_exe.sv - execute stage: ID/EX pipeline register plus ALU
// Purpose: registers decoded operands/control every clock (no stall/flush),
//          computes the ALU result from the registered values and forwards
//          sideband fields unchanged to MEM.
// Ports:   clk, resetn (async active-low); *_d_i from ID; alu_result_e_o
//          (combinational from E registers) and registered *_e_o copies.
module pipeline_exe
  import pipeline_exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      alu_op_d_i,
  input  logic [XLEN-1:0] rs1_d_i,
  input  logic [XLEN-1:0] rs2_d_i,
  input  logic [XLEN-1:0] extended_imm_d_i,
  input  logic [XLEN-1:0] pc_plus4_d_i,
  input  logic [2:0]      dmem_type_d_i,
  input  logic            reg_write_en_d_i,
  input  logic [4:0]      rd_idx_d_i,
  input  logic [1:0]      result_src_d_i,
  input  logic            instr_illegal_d_i,
  output logic [XLEN-1:0] alu_result_e_o,
  output logic [2:0]      dmem_type_e_o,
  output logic [XLEN-1:0] extended_imm_e_o,
  output logic [XLEN-1:0] pc_plus4_e_o,
  output logic            reg_write_en_e_o,
  output logic [4:0]      rd_idx_e_o,
  output logic [1:0]      result_src_e_o,
  output logic            instr_illegal_e_o
);

  logic [4:0]      alu_op_e;
  logic [XLEN-1:0] a_e;
  logic [XLEN-1:0] b_e;

  // Reset value is ADD with zero operands, so the ALU output reads 0
  // while resetn is low without any extra gating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_op_e          <= ALU_ADD;
      a_e               <= '0;
      b_e               <= '0;
      extended_imm_e_o  <= '0;
      pc_plus4_e_o      <= '0;
      dmem_type_e_o     <= DMEM_NONE;
      reg_write_en_e_o  <= 1'b0;
      rd_idx_e_o        <= '0;
      result_src_e_o    <= RESULT_SRC_ALU;
      instr_illegal_e_o <= 1'b0;
    end else begin
      alu_op_e          <= alu_op_d_i;
      a_e               <= rs1_d_i;
      b_e               <= rs2_d_i;
      extended_imm_e_o  <= extended_imm_d_i;
      pc_plus4_e_o      <= pc_plus4_d_i;
      dmem_type_e_o     <= dmem_type_d_i;
      reg_write_en_e_o  <= reg_write_en_d_i;
      rd_idx_e_o        <= rd_idx_d_i;
      result_src_e_o    <= result_src_d_i;
      instr_illegal_e_o <= instr_illegal_d_i;
    end
  end

  exe_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op_e),
    .a      (a_e),
    .b      (b_e),
    .result (alu_result_e_o)
  );

endmodule

// File: tb/tb_pipeline_exe.sv
// tb/tb_pipeline_exe.sv - self-checking bench for pipeline_exe
module tb_pipeline_exe;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [4:0]  alu_op_d_i;
  logic [31:0] rs1_d_i, rs2_d_i, extended_imm_d_i, pc_plus4_d_i;
  logic [2:0]  dmem_type_d_i;
  logic        reg_write_en_d_i;
  logic [4:0]  rd_idx_d_i;
  logic [1:0]  result_src_d_i;
  logic        instr_illegal_d_i;
  logic [31:0] alu_result_e_o, extended_imm_e_o, pc_plus4_e_o;
  logic [2:0]  dmem_type_e_o;
  logic        reg_write_en_e_o;
  logic [4:0]  rd_idx_e_o;
  logic [1:0]  result_src_e_o;
  logic        instr_illegal_e_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  dmem;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic        ill;
  } exp_t;

  pipeline_exe dut (
    .clk               (clk),
    .resetn            (resetn),
    .alu_op_d_i        (alu_op_d_i),
    .rs1_d_i           (rs1_d_i),
    .rs2_d_i           (rs2_d_i),
    .extended_imm_d_i  (extended_imm_d_i),
    .pc_plus4_d_i      (pc_plus4_d_i),
    .dmem_type_d_i     (dmem_type_d_i),
    .reg_write_en_d_i  (reg_write_en_d_i),
    .rd_idx_d_i        (rd_idx_d_i),
    .result_src_d_i    (result_src_d_i),
    .instr_illegal_d_i (instr_illegal_d_i),
    .alu_result_e_o    (alu_result_e_o),
    .dmem_type_e_o     (dmem_type_e_o),
    .extended_imm_e_o  (extended_imm_e_o),
    .pc_plus4_e_o      (pc_plus4_e_o),
    .reg_write_en_e_o  (reg_write_en_e_o),
    .rd_idx_e_o        (rd_idx_e_o),
    .result_src_e_o    (result_src_e_o),
    .instr_illegal_e_o (instr_illegal_e_o)
  );

  always #5 clk = ~clk;

  // Reference ALU written with plain arithmetic: shifts as multiply/divide
  // by powers of two, arithmetic right shift via complement identity.
  function automatic logic [31:0] ref_alu(int unsigned op, logic [31:0] a, logic [31:0] b);
    int unsigned s;
    logic [31:0] pow;
    s   = b % 32;
    pow = 32'd1 << s;
    case (op)
      0:  return 32'(64'(a) + 64'(b));
      1:  return 32'(64'(a) + 64'(~b) + 64'd1);
      2:  return 32'(64'(a) * 64'(pow));
      3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a / pow;
      7:  return a[31] ? ~((~a) / pow) : a / pow;
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.res  = ref_alu(alu_op_d_i, rs1_d_i, rs2_d_i);
    e.imm  = extended_imm_d_i;
    e.pc   = pc_plus4_d_i;
    e.dmem = dmem_type_d_i;
    e.we   = reg_write_en_d_i;
    e.rd   = rd_idx_d_i;
    e.src  = result_src_d_i;
    e.ill  = instr_illegal_d_i;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.res = '0; e.imm = '0; e.pc = '0; e.dmem = '0;
    e.we = 1'b0; e.rd = '0; e.src = '0; e.ill = 1'b0;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(string tag, exp_t e);
    chk({tag, ".res"},  alu_result_e_o, e.res);
    chk({tag, ".imm"},  extended_imm_e_o, e.imm);
    chk({tag, ".pc"},   pc_plus4_e_o, e.pc);
    chk({tag, ".dmem"}, 32'(dmem_type_e_o), 32'(e.dmem));
    chk({tag, ".we"},   32'(reg_write_en_e_o), 32'(e.we));
    chk({tag, ".rd"},   32'(rd_idx_e_o), 32'(e.rd));
    chk({tag, ".src"},  32'(result_src_e_o), 32'(e.src));
    chk({tag, ".ill"},  32'(instr_illegal_e_o), 32'(e.ill));
  endtask

  task automatic set_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    alu_op_d_i = op;
    rs1_d_i    = a;
    rs2_d_i    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_case(string tag, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp);
    set_alu(op, a, b);
    tick();
    chk(tag, alu_result_e_o, exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;

    // Load a nonzero instruction, then pull reset mid-cycle.
    set_alu(5'd0, 32'd3, 32'd4);
    extended_imm_d_i  = 32'h1234_5678;
    pc_plus4_d_i      = 32'h0000_0040;
    dmem_type_d_i     = 3'd2;
    reg_write_en_d_i  = 1'b1;
    rd_idx_d_i        = 5'd7;
    result_src_d_i    = 2'd1;
    instr_illegal_d_i = 1'b1;
    e = expect_now();
    tick();
    check_outputs("preload", e);

    #2 resetn = 1'b0;
    #1 check_outputs("async_rst", zero_exp());
    tick();
    tick();
    check_outputs("rst_hold", zero_exp());
    resetn = 1'b1;
    #2 check_outputs("rst_release", zero_exp());
    e = expect_now();
    tick();
    check_outputs("first_load", e);

    // Directed ALU corners.
    alu_case("add_ovf",  5'd0,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    alu_case("sub_neg",  5'd1,  32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_case("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("slt_neg",  5'd3,  32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_case("sltu_big", 5'd4,  32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("slt_eq",   5'd3,  32'd1, 32'd1, 32'd0);
    alu_case("sra",      5'd7,  32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_case("srl",      5'd6,  32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_case("sll_b33",  5'd2,  32'd1, 32'd33, 32'd2);
    alu_case("passb",    5'd10, 32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000);

    // Pass-through of sideband with an unused op code.
    set_alu(5'd31, 32'h1234_5678, 32'h9ABC_DEF0);
    rd_idx_d_i        = 5'd31;
    dmem_type_d_i     = 3'd5;
    result_src_d_i    = 2'd3;
    extended_imm_d_i  = 32'hDEAD_BEEF;
    pc_plus4_d_i      = 32'h0000_0104;
    instr_illegal_d_i = 1'b1;
    reg_write_en_d_i  = 1'b1;
    tick();
    e.res = 32'd0; e.imm = 32'hDEAD_BEEF; e.pc = 32'h104; e.dmem = 3'd5;
    e.we = 1'b1; e.rd = 5'd31; e.src = 2'd3; e.ill = 1'b1;
    check_outputs("passthru", e);

    // Back-to-back: a new op each cycle, result every cycle.
    set_alu(5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    chk("b2b_xor", alu_result_e_o, 32'hFF00_FF00);
    set_alu(5'd8, 32'h0000_00F0, 32'h0000_000F);
    tick();
    chk("b2b_or", alu_result_e_o, 32'h0000_00FF);
    set_alu(5'd9, 32'hFFFF_0000, 32'h0F0F_0F0F);
    tick();
    chk("b2b_and", alu_result_e_o, 32'h0F0F_0000);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        alu_op_d_i = 5'($urandom_range(11, 31));
      else
        alu_op_d_i = 5'($urandom_range(0, 10));
      rs1_d_i           = rand_operand();
      rs2_d_i           = rand_operand();
      extended_imm_d_i  = $urandom;
      pc_plus4_d_i      = $urandom;
      dmem_type_d_i     = 3'($urandom);
      reg_write_en_d_i  = 1'($urandom);
      rd_idx_d_i        = 5'($urandom);
      result_src_d_i    = 2'($urandom);
      instr_illegal_d_i = 1'($urandom);
      e = expect_now();
      tick();
      check_outputs($sformatf("rand%0d", i), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
